// File: rtl/sub_serial_8_bit.sv
// sub_serial_8_bit: digit-serial subtractor computing X - Y, DIGIT bits per
// clock, LSB first, with the borrow carried between cycles in a flop.
//
// Optional feature macro: SUB_SERIAL_ZERO_FLAG_EN adds a registered 'zero'
// output (1 iff diff == 0), updated together with diff.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   request, accepted only while ready=1
//   X, Y      in   minuend / subtrahend, sampled on the accepted start edge
//   ready     out  high in IDLE
//   done      out  one-cycle pulse, result valid
//   diff      out  X - Y mod 2^N, held until the next result
//   borrow    out  1 iff unsigned X < Y
//   overflow  out  signed overflow of X - Y
//   zero      out  (SUB_SERIAL_ZERO_FLAG_EN only) diff == 0
module sub_serial_8_bit #(
   parameter int unsigned N     = 8,
   parameter int unsigned DIGIT = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] X,
   input  logic [N-1:0] Y,
   output logic         ready,
   output logic         done,
   output logic [N-1:0] diff,
   output logic         borrow,
   output logic         overflow
`ifdef SUB_SERIAL_ZERO_FLAG_EN
   ,
   output logic         zero
`endif
);

   localparam int unsigned STEPS = N / DIGIT;
   localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     xs_q, xs_d;
   logic [N-1:0]     ys_q, ys_d;
   logic [N-1:0]     res_q, res_d;
   logic             b_q, b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             xmsb_q, xmsb_d;
   logic             ymsb_q, ymsb_d;
   logic [N-1:0]     diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
`ifdef SUB_SERIAL_ZERO_FLAG_EN
   logic             zero_q, zero_d;
`endif

   logic [DIGIT:0]   step;       // {borrow_out, digit} of this cycle
   logic [N-1:0]     res_shift;  // result register after inserting this digit

   // Next-state, datapath and registered-output logic
   always_comb begin
      state_d  = state_q;
      xs_d     = xs_q;
      ys_d     = ys_q;
      res_d    = res_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      xmsb_d   = xmsb_q;
      ymsb_d   = ymsb_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
`ifdef SUB_SERIAL_ZERO_FLAG_EN
      zero_d   = zero_q;
`endif

      step      = {1'b0, xs_q[DIGIT-1:0]} - {1'b0, ys_q[DIGIT-1:0]}
                  - (DIGIT+1)'(b_q);
      // New digit enters at the top; after STEPS cycles the LSB digit is at bit 0
      res_shift = N'({step[DIGIT-1:0], res_q} >> DIGIT);

      case (state_q)
         IDLE: begin
            if (start) begin
               xs_d    = X;
               ys_d    = Y;
               res_d   = '0;
               b_d     = 1'b0;
               cnt_d   = '0;
               xmsb_d  = X[N-1];
               ymsb_d  = Y[N-1];
               state_d = RUN;
            end
         end
         RUN: begin
            res_d = res_shift;
            xs_d  = xs_q >> DIGIT;
            ys_d  = ys_q >> DIGIT;
            b_d   = step[DIGIT];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               state_d  = DONE;
               diff_d   = res_shift;
               borrow_d = step[DIGIT];
               ovf_d    = (xmsb_q != ymsb_q) && (res_shift[N-1] != xmsb_q);
`ifdef SUB_SERIAL_ZERO_FLAG_EN
               zero_d   = (res_shift == '0);
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
      done_d  = (state_d == DONE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         xs_q     <= '0;
         ys_q     <= '0;
         res_q    <= '0;
         b_q      <= 1'b0;
         cnt_q    <= '0;
         xmsb_q   <= 1'b0;
         ymsb_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
`ifdef SUB_SERIAL_ZERO_FLAG_EN
         zero_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         xs_q     <= xs_d;
         ys_q     <= ys_d;
         res_q    <= res_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         xmsb_q   <= xmsb_d;
         ymsb_q   <= ymsb_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
`ifdef SUB_SERIAL_ZERO_FLAG_EN
         zero_q   <= zero_d;
`endif
      end
   end

   assign ready    = ready_q;
   assign done     = done_q;
   assign diff     = diff_q;
   assign borrow   = borrow_q;
   assign overflow = ovf_q;
`ifdef SUB_SERIAL_ZERO_FLAG_EN
   assign zero     = zero_q;
`else
   // No zero flag in this build
`endif

endmodule

// File: tb/tb_sub_serial_8_bit.sv
module tb_sub_serial_8_bit;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] X, Y;
   logic       ready, done, borrow, overflow;
   logic [7:0] diff;
`ifdef SUB_SERIAL_ZERO_FLAG_EN
   logic       zero;
`endif

   sub_serial_8_bit #(.N(8), .DIGIT(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .X        (X),
      .Y        (Y),
      .ready    (ready),
      .done     (done),
      .diff     (diff),
      .borrow   (borrow),
      .overflow (overflow)
`ifdef SUB_SERIAL_ZERO_FLAG_EN
      ,
      .zero     (zero)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       b;
      logic       o;
      logic       z;
   } exp_t;

   exp_t sb[$];
   int   done_cyc[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: each cycle with done high consumes one scoreboard entry
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         done_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("diff", 32'(diff), 32'(e.d));
            chk("borrow", 32'(borrow), 32'(e.b));
            chk("overflow", 32'(overflow), 32'(e.o));
`ifdef SUB_SERIAL_ZERO_FLAG_EN
            chk("zero", 32'(zero), 32'(e.z));
`endif
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_timeout", 32'(ready), 32'(1));
   endtask

   // Issue one operation, wait for done, check latency measured from the
   // edge after which start was raised.
   task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] d, input logic b, input logic o);
      int c0;
      int n = 0;
      wait_ready();
      sb.push_back('{d: d, b: b, o: o, z: (d == 8'h00)});
      start = 1'b1;
      X     = x;
      Y     = y;
      c0    = cyc;
      @(negedge clk);
      start = 1'b0;
      chk("ready_low_in_run", 32'(ready), 32'(0));
      X = 8'($urandom);
      Y = 8'($urandom);
      while (!done && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", 32'(done), 32'(1));
      chk("latency", 32'(cyc - c0), 32'(5));
      @(negedge clk);
      chk("done_single", 32'(done), 32'(0));
      chk("ready_after_done", 32'(ready), 32'(1));
   endtask

   initial begin
      int n0;
      int n;
      rst   = 1'b1;
      start = 1'b0;
      X     = '0;
      Y     = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'(1));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_diff", 32'(diff), 32'(0));
      chk("rst_borrow", 32'(borrow), 32'(0));
      chk("rst_overflow", 32'(overflow), 32'(0));
      rst = 1'b0;
      @(negedge clk);

      run_op(8'd100, 8'd58, 8'd42, 1'b0, 1'b0);
      run_op(8'h05, 8'h0A, 8'hFB, 1'b1, 1'b0);
      run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

      // Reset during the 2nd RUN cycle: everything back to reset values, no done
      wait_ready();
      n0    = done_cyc.size();
      start = 1'b1;
      X     = 8'hC8;
      Y     = 8'h14;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_diff", 32'(diff), 32'(0));
      chk("midrst_borrow", 32'(borrow), 32'(0));
      chk("midrst_overflow", 32'(overflow), 32'(0));
      chk("midrst_ready", 32'(ready), 32'(1));
      chk("midrst_done", 32'(done), 32'(0));
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("midrst_no_done", 32'(done_cyc.size()), 32'(n0));

      run_op(8'hC8, 8'h14, 8'hB4, 1'b0, 1'b0);
      run_op(8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0);
      run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);

      // Start requests during RUN and DONE must be ignored
      wait_ready();
      n0 = done_cyc.size();
      sb.push_back('{d: 8'h00, b: 1'b0, o: 1'b0, z: 1'b1});
      start = 1'b1;
      X     = 8'h33;
      Y     = 8'h33;
      @(negedge clk);
      start = 1'b1;
      X     = 8'hFF;
      Y     = 8'h00;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("ign_done_seen", 32'(done), 32'(1));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("ign_single_done", 32'(done_cyc.size()), 32'(n0 + 1));
      chk("ign_ready", 32'(ready), 32'(1));

      // start held high for 20 cycles: four back-to-back operations
      wait_ready();
      n0 = done_cyc.size();
      repeat (4) sb.push_back('{d: 8'hF0, b: 1'b1, o: 1'b0, z: 1'b0});
      start = 1'b1;
      X     = 8'h10;
      Y     = 8'h20;
      repeat (20) @(negedge clk);
      start = 1'b0;
      n = 0;
      while (done_cyc.size() < n0 + 4 && n < 40) begin
         @(negedge clk);
         n++;
      end
      repeat (8) @(negedge clk);
      chk("b2b_count", 32'(done_cyc.size()), 32'(n0 + 4));
      if (done_cyc.size() == n0 + 4) begin
         for (int i = 1; i < 4; i++)
            chk("b2b_period", 32'(done_cyc[n0+i] - done_cyc[n0+i-1]), 32'(6));
      end

      chk("scoreboard_empty", 32'(sb.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
